aes_iter_ctrl: RTL and testbench
================================

Name: aes_iter_ctrl

Overview:
- Sequencer for a single shared AES-128 round datapath: sub_byte -> shift_row -> mix_col -> key_gen.
- Replaces the fully unrolled ten-instance pipeline with one datapath used iteratively.
- Owns the state register, round-key register, round counter and Rcon generator.
- Accepts plaintext/key via valid/ready, runs ten rounds, presents ciphertext via valid/ready.
- Sits between the host bus interface and the round datapath.

Parameters:
- NUM_ROUNDS, 10, number of rounds; AES-128 only, other values unsupported.
- RCON_INIT, 8'h01, Rcon byte used for round 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset; single clock domain
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  controller can accept
- in_data  in  128  plaintext, bit 0 = MSB
- in_key  in  128  cipher key, bit 0 = MSB
- abort  in  1  synchronous cancel of the current block
- out_valid  out  1  ciphertext valid
- out_ready  in  1  sink accepts ciphertext
- out_data  out  128  ciphertext (= state_q)
- busy  out  1  high in ROUND
- dp_state  out  128  round datapath state input (= state_q)
- dp_key  out  128  previous round key to key_gen (= rkey_q)
- dp_rcon  out  32  {rcon_q, 24'h0} to key_gen
- dp_last  out  1  final round: datapath bypasses mix_col
- dp_state_nxt  in  128  datapath result after AddRoundKey
- dp_key_nxt  in  128  next round key from key_gen

Behaviour:
- FSM states: IDLE, ROUND, DONE.
- Reset (rst_n=0 at edge), from any state including mid-ROUND: state IDLE; state_q, rkey_q = 0; rcon_q = RCON_INIT; rnd_cnt = 0; out_valid = 0; busy = 0; in_ready = 1 once rst_n is high. No partial result is ever emitted.
- in_ready = 1 in IDLE; in DONE, in_ready = out_ready (back-to-back); 0 in ROUND.
- Accept (in_valid & in_ready): state_q <= in_data ^ in_key (pre-round AddRoundKey); rkey_q <= in_key; rcon_q <= RCON_INIT; rnd_cnt <= 1; go to ROUND.
- ROUND, each cycle:
  - state_q <= dp_state_nxt; rkey_q <= dp_key_nxt.
  - rcon_q <= xtime(rcon_q): shift left 1, XOR 8'h1b if MSB was set. Sequence 01,02,04,08,10,20,40,80,1b,36.
  - rnd_cnt <= rnd_cnt + 1.
  - dp_last = (rnd_cnt == NUM_ROUNDS).
  - When rnd_cnt == NUM_ROUNDS: capture, then go to DONE.
- Latency: out_valid rises 11 clocks after the accept edge. Throughput: one block per 11 cycles with out_ready held high.
- DONE: out_valid = 1; out_data stable until handshake.
  - out_ready = 1 with no new in_valid -> IDLE.
  - out_ready = 1 with in_valid = 1 -> accept the new block, go to ROUND the same edge.
  - out_ready = 0 -> hold indefinitely; inputs ignored.
- abort = 1 in ROUND -> IDLE next edge, no out_valid; rcon_q and rnd_cnt reset.
  - abort in IDLE or DONE is ignored; a pending output is not dropped.
  - abort has priority over round completion on the same edge.
- in_data and in_key are sampled only on the accept edge; later changes have no effect.
- dp_* outputs are driven combinationally from registers; no combinational path from in_* to out_*.

Decomposition:
- Shared package aes_pkg holds:
  - FSM state enum (IDLE, ROUND, DONE).
  - AES_NR = 10, RCON_INIT, the xtime function, block width 128.
- One natural sub-module: aes_rcon_gen (rcon register plus xtime; load and step inputs).
- The round datapath stays external, so one instance can be shared with a future decrypt sequencer.

Test Plan:
- Bench datapath model (sub_byte/shift_row/mix_col/key_gen with dp_last mix_col bypass) is used for all cases.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32; out_valid exactly 11 clocks after accept; dp_rcon bytes 01..36 in order; dp_last high only in round 10.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: out_ready = 0 for 20 cycles -> out_valid and out_data stable, in_ready = 0. Then out_ready = 1 with next block valid -> accepted the same edge; second result after 11 more clocks.
- abort asserted in round 5 -> IDLE next cycle, out_valid never rises. Next block (App. B vectors) produces the correct ciphertext.
- rst_n low for one cycle during round 7 -> all outputs at reset values, in_ready = 1. Next encryption is correct.
- in_data and in_key toggled randomly during ROUND -> result unchanged from the App. C.1 value.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round count, Rcon seed,
// sequencer state encoding and the GF(2^8) xtime helper.
package aes_pkg;

   localparam int         AES_NR        = 10;
   localparam int         AES_BLK_W     = 128;
   localparam logic [7:0] AES_RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } aes_state_e;

   // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: load restarts the sequence at RCON_INIT,
// step advances it by one xtime.
module aes_rcon_gen
   import aes_pkg::*;
#(
   parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       step,
   output logic [7:0] rcon
);

   logic [7:0] rcon_d;
   logic [7:0] rcon_q;

   always_comb begin
      rcon_d = rcon_q;
      if (load) begin
         rcon_d = RCON_INIT;
      end else if (step) begin
         rcon_d = xtime(rcon_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rcon_q <= RCON_INIT;
      end else begin
         rcon_q <= rcon_d;
      end
   end

   assign rcon = rcon_q;

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encrypt sequencer driving one shared external round
// datapath; byte 0 of every 128-bit bus sits in bits 127:120.
module aes_iter_ctrl
   import aes_pkg::*;
#(
   parameter int         NUM_ROUNDS = AES_NR,
   parameter logic [7:0] RCON_INIT  = AES_RCON_INIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   input  logic [AES_BLK_W-1:0] in_key,
   input  logic                 abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic                 busy,
   output logic [AES_BLK_W-1:0] dp_state,
   output logic [AES_BLK_W-1:0] dp_key,
   output logic [31:0]          dp_rcon,
   output logic                 dp_last,
   input  logic [AES_BLK_W-1:0] dp_state_nxt,
   input  logic [AES_BLK_W-1:0] dp_key_nxt
);

   localparam int CNT_W = $clog2(NUM_ROUNDS + 2);

   aes_state_e           st_d, st_q;
   logic [AES_BLK_W-1:0] state_d, state_q;
   logic [AES_BLK_W-1:0] rkey_d, rkey_q;
   logic [CNT_W-1:0]     rnd_cnt_d, rnd_cnt_q;
   logic                 out_valid_d, out_valid_q;
   logic                 busy_d, busy_q;
   logic                 idle_d, idle_q;
   logic                 accept;
   logic                 last_round;
   logic                 rcon_load;
   logic                 rcon_step;
   logic [7:0]           rcon;

   aes_rcon_gen #(
      .RCON_INIT (RCON_INIT)
   ) u_rcon_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (rcon_load),
      .step  (rcon_step),
      .rcon  (rcon)
   );

   // In DONE a new block may enter on the same edge the result leaves.
   assign in_ready   = idle_q | (out_valid_q & out_ready);
   assign accept     = in_valid & in_ready;
   assign last_round = (st_q == ROUND) && (rnd_cnt_q == CNT_W'(NUM_ROUNDS));

   always_comb begin
      st_d      = st_q;
      state_d   = state_q;
      rkey_d    = rkey_q;
      rnd_cnt_d = rnd_cnt_q;
      rcon_load = 1'b0;
      rcon_step = 1'b0;
      if (accept) begin
         state_d   = in_data ^ in_key;
         rkey_d    = in_key;
         rnd_cnt_d = CNT_W'(1);
         rcon_load = 1'b1;
         st_d      = ROUND;
      end else begin
         case (st_q)
            ROUND: begin
               if (abort) begin
                  rnd_cnt_d = '0;
                  rcon_load = 1'b1;
                  st_d      = IDLE;
               end else begin
                  state_d   = dp_state_nxt;
                  rkey_d    = dp_key_nxt;
                  rnd_cnt_d = rnd_cnt_q + 1'b1;
                  rcon_step = 1'b1;
                  if (last_round) begin
                     st_d = DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  st_d = IDLE;
               end
            end
            default: st_d = IDLE;
         endcase
      end
      idle_d      = (st_d == IDLE);
      busy_d      = (st_d == ROUND);
      out_valid_d = (st_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q        <= IDLE;
         state_q     <= '0;
         rkey_q      <= '0;
         rnd_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         st_q        <= st_d;
         state_q     <= state_d;
         rkey_q      <= rkey_d;
         rnd_cnt_q   <= rnd_cnt_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         idle_q      <= idle_d;
      end
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_data  = state_q;
   assign dp_state  = state_q;
   assign dp_key    = rkey_q;
   assign dp_rcon   = {rcon, 24'h0};
   assign dp_last   = last_round;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: a behavioural AES round/key-schedule model closes
// the datapath loop and a queue of expected ciphertexts scores each result.
module tb_aes_iter_ctrl;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         abort;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   logic [127:0] dp_state;
   logic [127:0] dp_key;
   logic [31:0]  dp_rcon;
   logic         dp_last;
   logic [127:0] dp_state_nxt;
   logic [127:0] dp_key_nxt;

   int           checks   = 0;
   int           failures = 0;
   logic [127:0] exp_q[$];
   logic [31:0]  rcon_log[$];
   logic         last_log[$];
   bit           mon_en = 1'b0;
   logic [7:0]   sbox[256];

   always #5 clk = ~clk;

   aes_iter_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_key       (in_key),
      .abort        (abort),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .dp_state     (dp_state),
      .dp_key       (dp_key),
      .dp_rcon      (dp_rcon),
      .dp_last      (dp_last),
      .dp_state_nxt (dp_state_nxt),
      .dp_key_nxt   (dp_key_nxt)
   );

   // ---------------- AES reference datapath ----------------
   function automatic logic [7:0] m_xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = m_xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   initial begin
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
      end
   end

   function automatic logic [127:0] key_next(input logic [127:0] k, input logic [31:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ rc;
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
      logic [7:0]   b [16];
      logic [7:0]   sh[16];
      logic [7:0]   m [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++) sh[rw+4*c] = b[rw + 4*((c+rw)%4)];
      for (int c = 0; c < 4; c++) begin
         m[4*c]   = gmul(sh[4*c], 8'h02) ^ gmul(sh[4*c+1], 8'h03) ^ sh[4*c+2] ^ sh[4*c+3];
         m[4*c+1] = sh[4*c] ^ gmul(sh[4*c+1], 8'h02) ^ gmul(sh[4*c+2], 8'h03) ^ sh[4*c+3];
         m[4*c+2] = sh[4*c] ^ sh[4*c+1] ^ gmul(sh[4*c+2], 8'h02) ^ gmul(sh[4*c+3], 8'h03);
         m[4*c+3] = gmul(sh[4*c], 8'h03) ^ sh[4*c+1] ^ sh[4*c+2] ^ gmul(sh[4*c+3], 8'h02);
      end
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? sh[i] : m[i];
      return r ^ k;
   endfunction

   always_comb begin
      dp_key_nxt   = '0;
      dp_state_nxt = '0;
      dp_key_nxt   = key_next(dp_key, dp_rcon);
      dp_state_nxt = round_fn(dp_state, dp_key_nxt, dp_last);
   end

   always @(negedge clk) begin
      if (mon_en && busy) begin
         rcon_log.push_back(dp_rcon);
         last_log.push_back(dp_last);
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_block(input logic [127:0] d, input logic [127:0] k,
                               input logic [127:0] exp, input bit push);
      bit ok;
      bit rdy;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_key   = k;
      for (int i = 0; i < 60 && !ok; i++) begin
         rdy = in_ready;
         tick();
         if (rdy) ok = 1'b1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
      end else if (push) begin
         exp_q.push_back(exp);
      end
   endtask

   // Entered just after the accept edge; counts that edge as edge 1.
   task automatic wait_output(input string name, input bit toggle, output int edges);
      logic [127:0] exp;
      edges = 1;
      while (!out_valid && edges < 40) begin
         if (toggle) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_key  = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         tick();
         edges++;
      end
      checks++;
      if (!out_valid) begin
         failures++;
         $display("[TB] FAIL %s_timeout: out_valid=0 after %0d edges, required 1", name, edges);
      end else if (exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL %s_unexpected: out_data=%h with empty scoreboard", name, out_data);
      end else begin
         exp = exp_q.pop_front();
         if (out_data !== exp) begin
            failures++;
            $display("[TB] FAIL %s_data: got %h, required %h", name, out_data, exp);
         end
      end
      if (out_valid && out_ready) tick();
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dp_state !== '0 ||
          dp_key !== '0 || dp_rcon !== 32'h0100_0000 || dp_last !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s: rdy=%b vld=%b busy=%b st=%h key=%h rcon=%h last=%b, required 1 0 0 0 0 01000000 0",
                  name, in_ready, out_valid, busy, dp_state, dp_key, dp_rcon, dp_last);
      end
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("[TB] FAIL %s: out_valid=1 seen, required 0", name);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_key    = '0;
      abort     = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      check_reset_outputs("reset_state");
   endtask

   task automatic test_fips_b();
      logic [7:0] rc_exp[10];
      int         edges;
      bit         bad;
      rc_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      rcon_log.delete();
      last_log.delete();
      mon_en = 1'b1;
      accept_block(PT_B, KEY_B, CT_B, 1'b1);
      wait_output("fips_b", 1'b0, edges);
      mon_en = 1'b0;
      checks++;
      if (edges !== 11) begin
         failures++;
         $display("[TB] FAIL fips_b_latency: %0d edges, required 11", edges);
      end
      bad = (rcon_log.size() != 10);
      for (int i = 0; i < 10 && !bad; i++)
         if (rcon_log[i] !== {rc_exp[i], 24'h0}) bad = 1'b1;
      checks++;
      if (bad) begin
         failures++;
         $display("[TB] FAIL fips_b_rcon: %0d rounds logged or wrong order, required 01..36", rcon_log.size());
      end
      bad = (last_log.size() != 10);
      for (int i = 0; i < 10 && !bad; i++)
         if (last_log[i] !== (i == 9)) bad = 1'b1;
      checks++;
      if (bad) begin
         failures++;
         $display("[TB] FAIL fips_b_dp_last: pattern wrong, required high only in round 10");
      end
   endtask

   task automatic test_fips_c();
      int edges;
      accept_block(PT_C, KEY_C, CT_C, 1'b1);
      wait_output("fips_c", 1'b0, edges);
   endtask

   task automatic test_backpressure();
      int  edges;
      bit  bad;
      out_ready = 1'b0;
      accept_block(PT_C, KEY_C, CT_C, 1'b1);
      wait_output("bp_first", 1'b0, edges);
      in_valid = 1'b1;
      in_data  = PT_B;
      in_key   = KEY_B;
      bad      = 1'b0;
      for (int i = 0; i < 20; i++) begin
         abort = (i == 10);
         tick();
         if (out_valid !== 1'b1 || out_data !== CT_C || in_ready !== 1'b0 || busy !== 1'b0)
            bad = 1'b1;
      end
      abort = 1'b0;
      checks++;
      if (bad) begin
         failures++;
         $display("[TB] FAIL bp_hold: vld=%b data=%h rdy=%b, required 1 %h 0", out_valid, out_data, in_ready, CT_C);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_ready_follow: in_ready=%b, required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      exp_q.push_back(CT_B);
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_same_edge: busy=%b vld=%b, required 1 0", busy, out_valid);
      end
      wait_output("bp_second", 1'b0, edges);
      checks++;
      if (edges !== 11) begin
         failures++;
         $display("[TB] FAIL bp_second_latency: %0d edges, required 11", edges);
      end
   endtask

   task automatic test_abort();
      int edges;
      accept_block(PT_C, KEY_C, CT_C, 1'b0);
      repeat (4) tick();
      checks++;
      if (dp_rcon !== 32'h1000_0000) begin
         failures++;
         $display("[TB] FAIL abort_round5_rcon: got %h, required 10000000", dp_rcon);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || dp_rcon !== 32'h0100_0000) begin
         failures++;
         $display("[TB] FAIL abort_idle: busy=%b rdy=%b vld=%b rcon=%h, required 0 1 0 01000000",
                  busy, in_ready, out_valid, dp_rcon);
      end
      expect_quiet("abort_no_output", 15);
      accept_block(PT_B, KEY_B, CT_B, 1'b1);
      wait_output("abort_next", 1'b0, edges);
   endtask

   task automatic test_reset_mid();
      int edges;
      accept_block(PT_B, KEY_B, CT_B, 1'b0);
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset_outputs("reset_mid_round");
      expect_quiet("reset_no_output", 15);
      accept_block(PT_C, KEY_C, CT_C, 1'b1);
      wait_output("reset_next", 1'b0, edges);
   endtask

   task automatic test_input_toggle();
      int edges;
      accept_block(PT_C, KEY_C, CT_C, 1'b1);
      wait_output("toggle", 1'b1, edges);
   endtask

   initial begin
      test_reset();
      test_fips_b();
      test_fips_c();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_input_toggle();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d results missing, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
